cc_branch_unit: RTL
===================

// Module: cc_branch_unit
// PURPOSE
//  Multi-context LC-3 condition-code register file plus branch resolver, for the datapath control path.
//  - Derives N/Z/P directly from the DATA_W-bit result bus.
//  - Holds one CC set per context.
//  - Resolves BR requests through a req/ready handshake.
//  - Stalls a branch against a context whose CC has never been loaded; a STALL_MAX timeout bounds the stall.
// PARAMETERS
//  DATA_W     16  width of result bus feeding CC derivation
//  NUM_CTX    2   number of independent CC register sets (>=1)
//  STALL_MAX  15  max WAIT cycles before forced not-taken (>=1)
//  CTX_W      $clog2(NUM_CTX) (min 1); derived, not overridable
// PORTS
//  Clk          in   1             system clock, all state on posedge
//  Reset_n      in   1             synchronous reset, active low
//  ld_cc        in   1             load CC of context cc_ctx from cc_data this edge
//  cc_ctx       in   CTX_W         context written by ld_cc
//  cc_data      in   DATA_W        result value (two's complement)
//  br_req       in   1             branch request valid
//  br_ctx       in   CTX_W         context whose CC is tested
//  br_nzp       in   3             IR[11:9] mask {n,z,p}
//  br_ready     out  1             unit accepts br_req this cycle
//  br_valid     out  1             one-cycle pulse: result valid
//  br_enable    out  1             branch taken (qualified by br_valid)
//  br_timeout   out  1             with br_valid: result forced by stall timeout
//  cc_flat      out  3*NUM_CTX     {n,z,p} of every context; ctx k at [3k+2:3k]
// BEHAVIOUR
//  Reset (Reset_n=0 at posedge):
//   - all CC=3'b000; cc_vld[k]=0; state=IDLE; stall counter=0
//   - br_valid=0, br_enable=0, br_timeout=0
//   - br_ready=1 once out of reset
//  CC derivation: n=cc_data[DATA_W-1]; z=(cc_data==0); p=~n&~z. Exactly one bit set after any load.
//  On ld_cc: CC[cc_ctx]<=derived, cc_vld[cc_ctx]<=1. Out-of-range cc_ctx (non-pow2 NUM_CTX) is ignored.
//  Effective CC (fwd): ld_cc && cc_ctx==br_ctx in the same cycle -> use derived value, else CC[br_ctx].
//   Same for vld.
//  Taken = (nzp==3'b111) | |(nzp & effCC). nzp=000 never taken. 111 taken even when CC is invalid.
//  FSM, states IDLE, WAIT:
//   IDLE, br_req & br_ready:
//    - if nzp==111, nzp==000 or eff vld=1: next edge br_valid=1, br_enable=Taken (latency 1); stay IDLE.
//    - else latch ctx/nzp, counter<=0, go WAIT.
//   WAIT: br_ready=0.
//    - A matching ld_cc resolves with the forwarded value: br_valid next edge, go IDLE.
//    - Otherwise counter++.
//    - When counter==STALL_MAX-1 with no load: br_valid=1, br_enable=0, br_timeout=1, go IDLE.
//   br_ready=1 in IDLE; back-to-back requests accepted every cycle in IDLE.
//   br_enable/br_timeout are 0 whenever br_valid=0.
//  Simultaneous ld_cc to another ctx during WAIT: updates that ctx only; no effect on the stall.
//  Reset mid-WAIT: request dropped, no br_valid issued.
//  ld_cc loads are accepted in every state, including the reset-release cycle.
// TESTING
//  1 Reset, ld_cc ctx0 data=16'h8000, then req ctx0 nzp=100 -> cc_flat[2:0]=100; br_valid+br_enable=1 one cycle after accept.
//  2 ld_cc ctx1 data=0 same cycle as req ctx1 nzp=010 -> forwarded: br_enable=1 at latency 1, no WAIT.
//  3 After reset, req ctx1 nzp=001 -> br_ready=0; ld_cc ctx1 data=16'h0005 three cycles later -> br_valid, br_enable=1 next edge.
//  4 Unloaded ctx, nzp=110, no loads -> br_valid, br_timeout=1, br_enable=0 exactly STALL_MAX cycles after accept.
//  5 Unloaded ctx: nzp=111 -> taken; nzp=000 -> not taken. Both latency 1, no stall.
//  6 Reset_n=0 during WAIT -> no br_valid; all cc_flat=0; the next request stalls again.

Source files
------------

// File: rtl/cc_branch_unit.sv
// LC-3 condition-code register file with one N/Z/P set per context, plus a BR resolver.
// A branch against a never-loaded context waits for its load, bounded by STALL_MAX cycles.
module cc_branch_unit #(
    parameter int  DATA_W    = 16,
    parameter int  NUM_CTX   = 2,
    parameter int  STALL_MAX = 15,
    localparam int CTX_W     = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 ld_cc,
    input  logic [CTX_W-1:0]     cc_ctx,
    input  logic [DATA_W-1:0]    cc_data,
    input  logic                 br_req,
    input  logic [CTX_W-1:0]     br_ctx,
    input  logic [2:0]           br_nzp,
    output logic                 br_ready,
    output logic                 br_valid,
    output logic                 br_enable,
    output logic                 br_timeout,
    output logic [3*NUM_CTX-1:0] cc_flat
);

    localparam int               CNT_W     = (STALL_MAX > 1) ? $clog2(STALL_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STALL_MAX - 1);
    localparam logic [CTX_W:0]   CTX_LIMIT = (CTX_W + 1)'(NUM_CTX);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Handshake: a request transfers on a rising edge where br_req && br_ready.
    // Each accepted request yields exactly one br_valid pulse unless reset intervenes.

    state_t                    state_q;
    logic [NUM_CTX-1:0][2:0]   cc_q;
    logic [NUM_CTX-1:0]        cc_vld_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [CTX_W-1:0]          wait_ctx_q;
    logic [2:0]                wait_nzp_q;
    logic                      br_valid_q;
    logic                      br_enable_q;
    logic                      br_timeout_q;

    logic                      n_flag;
    logic                      z_flag;
    logic [2:0]                der_cc;
    logic                      ld_ok;
    logic [2:0]                stored_cc;
    logic                      stored_vld;
    logic                      fwd;
    logic [2:0]                eff_cc;
    logic                      eff_vld;
    logic                      resolve_now;
    logic                      wait_hit;

    function automatic logic br_taken(input logic [2:0] nzp, input logic [2:0] cc);
        return (nzp == 3'b111) || (|(nzp & cc));
    endfunction

    assign n_flag = cc_data[DATA_W-1];
    assign z_flag = ~|cc_data;
    assign der_cc = {n_flag, z_flag, ~n_flag & ~z_flag};

    always_comb begin
        ld_ok      = ld_cc && ({1'b0, cc_ctx} < CTX_LIMIT);
        stored_cc  = 3'b000;
        stored_vld = 1'b0;
        for (int k = 0; k < NUM_CTX; k++) begin
            if (br_ctx == CTX_W'(k)) begin
                stored_cc  = cc_q[k];
                stored_vld = cc_vld_q[k];
            end
        end
        // A load in the same cycle as the request is forwarded to the resolver.
        fwd         = ld_ok && (cc_ctx == br_ctx);
        eff_cc      = fwd ? der_cc : stored_cc;
        eff_vld     = fwd ? 1'b1 : stored_vld;
        resolve_now = (br_nzp == 3'b111) || (br_nzp == 3'b000) || eff_vld;
        wait_hit    = ld_ok && (cc_ctx == wait_ctx_q);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            cc_q         <= '0;
            cc_vld_q     <= '0;
            cnt_q        <= '0;
            wait_ctx_q   <= '0;
            wait_nzp_q   <= 3'b000;
            br_valid_q   <= 1'b0;
            br_enable_q  <= 1'b0;
            br_timeout_q <= 1'b0;
        end else begin
            br_valid_q   <= 1'b0;
            br_enable_q  <= 1'b0;
            br_timeout_q <= 1'b0;

            for (int k = 0; k < NUM_CTX; k++) begin
                if (ld_ok && (cc_ctx == CTX_W'(k))) begin
                    cc_q[k]     <= der_cc;
                    cc_vld_q[k] <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (br_req) begin
                        if (resolve_now) begin
                            br_valid_q  <= 1'b1;
                            br_enable_q <= br_taken(br_nzp, eff_cc);
                        end else begin
                            wait_ctx_q <= br_ctx;
                            wait_nzp_q <= br_nzp;
                            cnt_q      <= '0;
                            state_q    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A matching load wins over a timeout landing on the same edge.
                    if (wait_hit) begin
                        br_valid_q  <= 1'b1;
                        br_enable_q <= br_taken(wait_nzp_q, der_cc);
                        state_q     <= S_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        br_valid_q   <= 1'b1;
                        br_timeout_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign br_ready   = (state_q == S_IDLE);
    assign br_valid   = br_valid_q;
    assign br_enable  = br_enable_q;
    assign br_timeout = br_timeout_q;
    assign cc_flat    = cc_q;

endmodule
